// File: rtl/shift_unit_pkg.sv
// Shared constants and types for the iterative MIPS shifter (shift_unit_seq).
// Op encodings, FSM state type and default geometry live here.
package shift_unit_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step for shift_unit_seq: returns acc shifted by one position per op.
// Rotate-right is only built when SHIFT_ROTR_EN is defined; otherwise op 11 acts as SRL.
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] step_o
);

    always_comb begin
        // NOTE: step_o gets a default before the case so no path leaves it unassigned (no latch).
        step_o = {1'b0, acc_i[WIDTH-1:1]};
        case (op_i)
            OP_SLL:  step_o = {acc_i[WIDTH-2:0], 1'b0};
            OP_SRL:  step_o = {1'b0, acc_i[WIDTH-1:1]};
            OP_SRA:  step_o = {acc_i[WIDTH-1], acc_i[WIDTH-1:1]};
`ifdef SHIFT_ROTR_EN
            OP_ROTR: step_o = {acc_i[0], acc_i[WIDTH-1:1]};
`else
            OP_ROTR: step_o = {1'b0, acc_i[WIDTH-1:1]};
`endif
            default: step_o = {1'b0, acc_i[WIDTH-1:1]};
        endcase
    end

endmodule

// File: rtl/shift_unit_seq.sv
// Iterative SLL/SRL/SRA(/ROTR) shifter, one bit per clock, Start/Busy/Done handshake.
// Optional rotate support selected by the SHIFT_ROTR_EN macro (see shift_step).
module shift_unit_seq
    import shift_unit_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic [WIDTH-1:0]   DataIn,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   DataOut
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   step_val;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i  (acc_q),
        .op_i   (op_q),
        .step_o (step_val)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        op_d       = op_q;
        data_out_d = data_out_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    op_d    = Op;
                    acc_d   = DataIn;
                    count_d = Shamt;
                    state_d = (Shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = step_val;
                count_d = count_q - SHAMT_W'(1);
                if (count_q == SHAMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next state so they can be registered
        // and still line up with the state they describe.
        if (state_d == DONE) begin
            data_out_d = acc_d;
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            op_q       <= OP_SLL;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            op_q       <= op_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign DataOut = data_out_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed self-checking bench for shift_unit_seq: latency, handshake, ignore-while-busy,
// mid-op reset and each shift op, with expected values computed by hand.
module tb_shift_unit_seq;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               Clk = 1'b0;
    logic               Reset;
    logic               Start;
    logic [1:0]         Op;
    logic [SHAMT_W-1:0] Shamt;
    logic [WIDTH-1:0]   DataIn;
    logic               Busy;
    logic               Done;
    logic [WIDTH-1:0]   DataOut;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [WIDTH-1:0] prev_out;

    always #5 Clk = ~Clk;

    shift_unit_seq #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .Op      (Op),
        .Shamt   (Shamt),
        .DataIn  (DataIn),
        .Busy    (Busy),
        .Done    (Done),
        .DataOut (DataOut)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    // Starts an op in the current cycle, then checks Busy/Done/DataOut every cycle until idle.
    // Operand inputs are scrambled after capture to show they no longer matter.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [SHAMT_W-1:0] sh,
                          input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] exp);
        Op = op; Shamt = sh; DataIn = din; Start = 1'b1;
        next_cycle();
        Start = 1'b0; Op = ~op; Shamt = ~sh; DataIn = ~din;
        for (int k = 1; k <= int'(sh) + 1; k++) begin
            check($sformatf("%s busy@t+%0d", tag, k), WIDTH'(Busy), WIDTH'(1));
            check($sformatf("%s done@t+%0d", tag, k), WIDTH'(Done), WIDTH'(k == int'(sh) + 1));
            if (k <= int'(sh))
                check($sformatf("%s hold@t+%0d", tag, k), DataOut, prev_out);
            else
                check($sformatf("%s result", tag), DataOut, exp);
            next_cycle();
        end
        check({tag, " idle busy"}, WIDTH'(Busy), '0);
        check({tag, " idle done"}, WIDTH'(Done), '0);
        check({tag, " idle data"}, DataOut, exp);
        prev_out = exp;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 2'b00; Shamt = '0; DataIn = '0;
        prev_out = '0;
        next_cycle();
        next_cycle();
        Reset = 1'b0;
        check("reset busy", WIDTH'(Busy), '0);
        check("reset done", WIDTH'(Done), '0);
        check("reset data", DataOut, '0);

        // Basic ops and boundary shift amounts.
        run_op("sll1x4",   2'b00, 5'd4,  32'h0000_0001, 32'h0000_0010);
        run_op("sra_neg31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("srl31",    2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
        run_op("srl0",     2'b01, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF);
        run_op("sra_pos4", 2'b10, 5'd4,  32'h4000_0000, 32'h0400_0000);
        run_op("sra_neg4", 2'b10, 5'd4,  32'hF000_0000, 32'hFF00_0000);
        run_op("sll31",    2'b00, 5'd31, 32'h0000_0003, 32'h8000_0000);

        // Start while busy is ignored; a Start in the first idle cycle is accepted.
        Op = 2'b01; Shamt = 5'd3; DataIn = 32'h0000_00F0; Start = 1'b1;
        next_cycle();                                   // t+1
        Start = 1'b0;
        check("ign busy t+1", WIDTH'(Busy), WIDTH'(1));
        next_cycle();                                   // t+2
        Start = 1'b1; Op = 2'b00; Shamt = 5'd1; DataIn = 32'h0000_1234;
        check("ign done t+2", WIDTH'(Done), '0);
        next_cycle();                                   // t+3
        Start = 1'b0;
        check("ign busy t+3", WIDTH'(Busy), WIDTH'(1));
        check("ign done t+3", WIDTH'(Done), '0);
        next_cycle();                                   // t+4
        check("ign done t+4", WIDTH'(Done), WIDTH'(1));
        check("ign data t+4", DataOut, 32'h0000_001E);
        next_cycle();                                   // t+5
        check("ign busy t+5", WIDTH'(Busy), '0);
        check("ign data t+5", DataOut, 32'h0000_001E);
        prev_out = 32'h0000_001E;
        run_op("after_ign", 2'b00, 5'd1, 32'h0000_1234, 32'h0000_2468);

        // Reset mid-operation aborts it with no Done pulse.
        Op = 2'b00; Shamt = 5'd8; DataIn = 32'h0000_0001; Start = 1'b1;
        next_cycle();                                   // t+1
        Start = 1'b0;
        next_cycle();                                   // t+2
        Reset = 1'b1;
        next_cycle();                                   // t+3
        Reset = 1'b0;
        check("abort busy", WIDTH'(Busy), '0);
        check("abort done", WIDTH'(Done), '0);
        check("abort data", DataOut, '0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("abort no done %0d", i), WIDTH'(Done), '0);
            next_cycle();
        end
        prev_out = '0;
        run_op("post_abort", 2'b01, 5'd2, 32'h0000_0100, 32'h0000_0040);

        // Op 11: rotate when enabled, zero-fill SRL otherwise.
`ifdef SHIFT_ROTR_EN
        run_op("op11_3x1", 2'b11, 5'd1, 32'h0000_0003, 32'h8000_0001);
        run_op("op11_x4",  2'b11, 5'd4, 32'h1234_5678, 32'h8123_4567);
`else
        run_op("op11_3x1", 2'b11, 5'd1, 32'h0000_0003, 32'h0000_0001);
        run_op("op11_x4",  2'b11, 5'd4, 32'h1234_5678, 32'h0123_4567);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
